// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the register-bank SPI slave.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA_WR,
    DATA_RD,
    WAIT_CS
  } spi_state_t;

  // The R/W flag sits in the MSB of the command word.
  function automatic int cmd_wr_bit_of(input int width);
    return width - 1;
  endfunction

  function automatic bit sample_on_leading(input bit cpha);
    return !cpha;
  endfunction

endpackage

// File: rtl/spi_slave_regs_sync.sv
// Multi-flop synchroniser for one asynchronous pin, plus edge detection
// against a previous-value flop.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI slave with auto-incrementing register bank, oversampled in the clk domain.
// Optional MISO echo of received write words: define SPI_SLAVE_WR_ECHO_EN.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 3,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spi_sclk,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic                          spi_miso_oe,
  output logic [WIDTH*(2**ADDR_W)-1:0]  reg_q,
  output logic                          wr_strobe,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic                          busy
);

  localparam int              CMD_WR_BIT  = cmd_wr_bit_of(WIDTH);
  localparam int              DEPTH       = 2 ** ADDR_W;
  localparam int              CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam bit              SAMPLE_LEAD = sample_on_leading(CPHA);

  logic       sclk_rise, sclk_fall, cs_n_s, mosi_s;
  logic       sclk_level_unused;
  logic [3:0] edges_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .din(spi_sclk), .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .din(spi_cs_n), .level(cs_n_s), .rise(edges_unused[0]), .fall(edges_unused[1])
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .din(spi_mosi), .level(mosi_s), .rise(edges_unused[2]), .fall(edges_unused[3])
  );

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
  assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

  spi_state_t state_q, state_d;
  logic       active;
  assign active = (state_q == CMD) || (state_q == DATA_WR) || (state_q == DATA_RD);

  // rx_shift keeps only WIDTH-1 bits: the newest bit is merged combinationally.
  logic [WIDTH-2:0]  rx_shift;
  logic [WIDTH-1:0]  rx_next, tx_shift, echo_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr_q, cmd_addr;
  logic              tx_loaded, word_done;
  logic [WIDTH-1:0]  bank [DEPTH];

  assign rx_next   = {rx_shift, mosi_s};
  assign cmd_addr  = rx_next[ADDR_W-1:0];
  assign word_done = active && sample_edge && (bit_cnt == LAST_BIT);

`ifdef SPI_SLAVE_WR_ECHO_EN
  assign echo_word = rx_next;
`else
  assign echo_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= cs_n_s ? IDLE : WAIT_CS;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_n_s) state_d = CMD;
      CMD: begin
        if (word_done) state_d = rx_next[CMD_WR_BIT] ? DATA_WR : DATA_RD;
        if (cs_n_s)    state_d = IDLE;
      end
      DATA_WR: if (cs_n_s) state_d = IDLE;
      DATA_RD: if (cs_n_s) state_d = IDLE;
      WAIT_CS: if (cs_n_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (active && sample_edge) rx_shift <= rx_next[WIDTH-2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      tx_shift  <= '0;
      tx_loaded <= 1'b0;
      spi_miso  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      bit_cnt   <= '0;
      addr_q    <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (!active) begin
        bit_cnt   <= '0;
        tx_shift  <= '0;
        tx_loaded <= 1'b0;
        spi_miso  <= 1'b0;
      end else begin
        if (sample_edge) bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        // The first shift edge after a load presents the MSB without shifting.
        if (shift_edge) begin
          if (tx_loaded) begin
            spi_miso  <= tx_shift[WIDTH-1];
            tx_loaded <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            spi_miso <= tx_shift[WIDTH-2];
          end
        end
        // A write completing alongside CS_N rising still commits.
        if (word_done) begin
          tx_loaded <= 1'b1;
          case (state_q)
            CMD: begin
              if (rx_next[CMD_WR_BIT]) begin
                addr_q   <= cmd_addr;
                tx_shift <= echo_word;
              end else begin
                addr_q   <= cmd_addr + 1'b1;
                tx_shift <= bank[cmd_addr];
              end
            end
            DATA_WR: begin
              bank[addr_q] <= rx_next;
              wr_strobe    <= 1'b1;
              wr_addr      <= addr_q;
              addr_q       <= addr_q + 1'b1;
              tx_shift     <= echo_word;
            end
            DATA_RD: begin
              tx_shift <= bank[addr_q];
              addr_q   <= addr_q + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg_q
    assign reg_q[i*WIDTH +: WIDTH] = bank[i];
  end

  assign spi_miso_oe = active;
  // WAIT_CS is a lockout, not a transaction, so it does not raise busy.
  assign busy        = active;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: mode 0 and mode 3 instances driven in lockstep.
module tb_spi_slave_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n = 1'b1, mosi = 1'b0, s = 1'b0, bits_active = 1'b0;
  logic sclk0, sclk3;

  assign sclk0 = s;
  assign sclk3 = bits_active ? s : 1'b1;

  always #5 clk = ~clk;

  logic        miso0, oe0, strobe0, busy0, miso3, oe3, strobe3, busy3;
  logic [63:0] regq0, regq3;
  logic [2:0]  waddr0, waddr3;

  spi_slave_regs #(.WIDTH(8), .ADDR_W(3), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .spi_sclk(sclk0), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .reg_q(regq0), .wr_strobe(strobe0),
    .wr_addr(waddr0), .busy(busy0)
  );
  spi_slave_regs #(.WIDTH(8), .ADDR_W(3), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .spi_sclk(sclk3), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso3), .spi_miso_oe(oe3), .reg_q(regq3), .wr_strobe(strobe3),
    .wr_addr(waddr3), .busy(busy3)
  );

`ifdef SPI_SLAVE_WR_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  int n_cmp = 0, n_fail = 0;
  int n_strb0 = 0, n_strb3 = 0;
  logic [2:0] log0 [16];
  logic [2:0] log3 [16];
  int lo_seen, hi_seen;

  always @(negedge clk) begin
    if (strobe0) begin
      if (n_strb0 < 16) log0[n_strb0] = waddr0;
      n_strb0++;
    end
    if (strobe3) begin
      if (n_strb3 < 16) log3[n_strb3] = waddr3;
      n_strb3++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    s = 1'b0;
    bits_active = 1'b0;
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic xfer_bits(input logic [7:0] w, input int nbits,
                           output logic [7:0] r0, output logic [7:0] r3);
    r0 = '0;
    r3 = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bits_active = 1'b1;
      s = 1'b0;
      mosi = w[i];
      wait_clk(4);
      r0[i] = miso0;
      r3[i] = miso3;
      if (!(oe0 && oe3 && busy0 && busy3)) lo_seen++;
      if (oe0 || oe3 || busy0 || busy3) hi_seen++;
      s = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " oe/busy"}, {60'd0, oe0, oe3, busy0, busy3}, 64'd0);
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    bit         first;
    bit         last;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r3;

    tbl[0] = '{8'h82, 8'h00,                  1'b1, 1'b0};
    tbl[1] = '{8'hA5, ECHO ? 8'h82 : 8'h00,   1'b0, 1'b0};
    tbl[2] = '{8'h3C, ECHO ? 8'hA5 : 8'h00,   1'b0, 1'b1};
    tbl[3] = '{8'h02, 8'h00,                  1'b1, 1'b0};
    tbl[4] = '{8'h00, 8'hA5,                  1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h3C,                  1'b0, 1'b1};
    tbl[6] = '{8'h87, 8'h00,                  1'b1, 1'b0};
    tbl[7] = '{8'h11, ECHO ? 8'h87 : 8'h00,   1'b0, 1'b0};
    tbl[8] = '{8'h22, ECHO ? 8'h11 : 8'h00,   1'b0, 1'b1};

    wait_clk(5);
    check("reset reg_q m0", regq0, 64'd0);
    check("reset reg_q m3", regq3, 64'd0);
    check("reset misc", {miso0, oe0, strobe0, busy0, waddr0, miso3, oe3, strobe3, busy3, waddr3}, 64'd0);
    rst = 1'b0;
    wait_clk(4);

    for (int k = 0; k < 9; k++) begin
      if (tbl[k].first) begin
        lo_seen = 0;
        cs_start();
      end
      xfer_bits(tbl[k].mosi, 8, r0, r3);
      check($sformatf("m0 vec%0d miso", k), r0, tbl[k].exp_miso);
      check($sformatf("m3 vec%0d miso", k), r3, tbl[k].exp_miso);
      if (tbl[k].last) begin
        cs_end();
        check($sformatf("vec%0d oe/busy low during xfer", k), 64'(lo_seen), 64'd0);
        check_idle_outputs($sformatf("vec%0d after cs high", k));
      end
    end

    check("m0 reg2", regq0[2*8 +: 8], 8'hA5);
    check("m0 reg3", regq0[3*8 +: 8], 8'h3C);
    check("m0 reg7", regq0[7*8 +: 8], 8'h11);
    check("m0 reg0", regq0[0*8 +: 8], 8'h22);
    check("m3 reg_q", regq3, regq0 & 64'h0 | {8'h11, 24'h0, 8'h3C, 8'hA5, 8'h00, 8'h22});
    check("m0 strobe count", 64'(n_strb0), 64'd4);
    check("m3 strobe count", 64'(n_strb3), 64'd4);
    check("m0 strobe addrs", {log0[0], log0[1], log0[2], log0[3]}, {3'd2, 3'd3, 3'd7, 3'd0});
    check("m3 strobe addrs", {log3[0], log3[1], log3[2], log3[3]}, {3'd2, 3'd3, 3'd7, 3'd0});

    // Abort a write mid-word, then retry it.
    cs_start();
    xfer_bits(8'h81, 8, r0, r3);
    xfer_bits(8'hFF, 5, r0, r3);
    cs_end();
    check("abort strobe count", 64'(n_strb0 + n_strb3), 64'd8);
    check("abort reg1 m0", regq0[1*8 +: 8], 8'h00);
    check("abort reg1 m3", regq3[1*8 +: 8], 8'h00);
    cs_start();
    xfer_bits(8'h81, 8, r0, r3);
    xfer_bits(8'h5A, 8, r0, r3);
    cs_end();
    check("retry reg1 m0", regq0[1*8 +: 8], 8'h5A);
    check("retry reg1 m3", regq3[1*8 +: 8], 8'h5A);
    check("retry strobe", {32'(n_strb0), 29'd0, log0[4]}, {32'd5, 29'd0, 3'd1});
    check("retry strobe m3", {32'(n_strb3), 29'd0, log3[4]}, {32'd5, 29'd0, 3'd1});

    // Reset in the middle of a read with CS_N held low.
    cs_start();
    xfer_bits(8'h02, 8, r0, r3);
    xfer_bits(8'h00, 4, r0, r3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst reg_q", regq0 | regq3, 64'd0);
    check("midrst misc", {miso0, oe0, strobe0, busy0, waddr0, miso3, oe3, strobe3, busy3, waddr3}, 64'd0);
    rst = 1'b0;
    hi_seen = 0;
    xfer_bits(8'h00, 4, r0, r3);
    xfer_bits(8'h81, 8, r0, r3);
    xfer_bits(8'h77, 8, r0, r3);
    check("locked out activity", 64'(hi_seen), 64'd0);
    check("locked out strobes", 64'(n_strb0 + n_strb3), 64'd10);
    check("locked out reg_q", regq0 | regq3, 64'd0);
    cs_end();
    cs_start();
    xfer_bits(8'h02, 8, r0, r3);
    xfer_bits(8'h00, 8, r0, r3);
    check("post-reset read m0", r0, 8'h00);
    check("post-reset read m3", r3, 8'h00);
    cs_end();
    check_idle_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
